// File: rtl/prod_acc_pkg.sv
// Shared types and width helpers for the sliding-window product accumulator.
package prod_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  // Window sum never exceeds N*(2^W-1)^2, which fits in 2W+log2(N) bits.
  function automatic int sum_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/prod_acc_buf.sv
// N-entry circular product buffer; oldest is the entry that the next write replaces.
module prod_acc_buf #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           clr,
  input  logic           we,
  input  logic [2*W-1:0] din,
  output logic [2*W-1:0] oldest
);

  localparam int PW = $clog2(N);

  logic [2*W-1:0] mem [N];
  logic [PW-1:0]  wr_ptr_reg;

  // Storage is intentionally never cleared; the accumulator ignores it until full.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // N is a power of two, so natural wrap of the pointer gives modulo-N.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
    end else if (we) begin
      wr_ptr_reg <= wr_ptr_reg + PW'(1);
    end
  end

  assign oldest = mem[wr_ptr_reg];

endmodule

// File: rtl/prod_acc.sv
// Sliding-window sum of the last N unsigned products with fill/full tracking.
// Optional average output enabled by defining PROD_ACC_AVG_EN.
module prod_acc
  import prod_acc_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         clr,
  input  logic                         vld,
  input  logic [2*W-1:0]               prod,
  output logic [sum_width(W, N)-1:0]   sum,
  output logic [$clog2(N):0]           cnt,
  output logic                         full,
  output logic                         out_vld
`ifdef PROD_ACC_AVG_EN
  ,
  output logic [2*W-1:0]               avg
`endif
);

  localparam int LOG2N = $clog2(N);
  localparam int SW    = sum_width(W, N);
  localparam int CW    = LOG2N + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  state_t          state_reg, state_next;
  logic [SW-1:0]   sum_reg, sum_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            full_reg, full_next;
  logic            out_vld_reg, out_vld_next;
  logic [2*W-1:0]  oldest;

  prod_acc_buf #(
    .W(W),
    .N(N)
  ) u_buf (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (clr),
    .we     (vld && !clr),
    .din    (prod),
    .oldest (oldest)
  );

  always_comb begin
    state_next   = state_reg;
    sum_next     = sum_reg;
    cnt_next     = cnt_reg;
    full_next    = full_reg;
    out_vld_next = 1'b0;
    if (clr) begin
      state_next = IDLE;
      sum_next   = '0;
      cnt_next   = '0;
      full_next  = 1'b0;
    end else if (vld) begin
      // Subtracting only once full keeps stale buffer entries out of the sum.
      if (state_reg == FULL) begin
        sum_next = sum_reg + SW'(prod) - SW'(oldest);
        cnt_next = CNT_FULL;
      end else begin
        sum_next = sum_reg + SW'(prod);
        cnt_next = cnt_reg + CW'(1);
      end
      full_next    = (cnt_next == CNT_FULL);
      out_vld_next = full_next;
      case (state_reg)
        IDLE:    state_next = full_next ? FULL : FILL;
        FILL:    state_next = full_next ? FULL : FILL;
        FULL:    state_next = FULL;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg   <= IDLE;
      sum_reg     <= '0;
      cnt_reg     <= '0;
      full_reg    <= 1'b0;
      out_vld_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sum_reg     <= sum_next;
      cnt_reg     <= cnt_next;
      full_reg    <= full_next;
      out_vld_reg <= out_vld_next;
    end
  end

  assign sum     = sum_reg;
  assign cnt     = cnt_reg;
  assign full    = full_reg;
  assign out_vld = out_vld_reg;

`ifdef PROD_ACC_AVG_EN
  logic [2*W-1:0] avg_reg;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      avg_reg <= '0;
    end else begin
      avg_reg <= sum_next[SW-1:LOG2N];
    end
  end

  assign avg = avg_reg;
`endif

endmodule

// File: tb/tb_prod_acc.sv
// Scoreboard bench for prod_acc: window-queue reference model, per-cycle monitor.
module tb_prod_acc;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = 2 * W + $clog2(N);
  localparam int CW = $clog2(N) + 1;

  typedef struct {
    int s;
    int c;
    int f;
    int ov;
  } exp_t;

  logic           clk;
  logic           rst_b;
  logic           clr;
  logic           vld;
  logic [2*W-1:0] prod;
  logic [SW-1:0]  sum;
  logic [CW-1:0]  cnt;
  logic           full;
  logic           out_vld;
`ifdef PROD_ACC_AVG_EN
  logic [2*W-1:0] avg;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;
  int   window[$];
  exp_t exp_q[$];

  prod_acc #(
    .W(W),
    .N(N)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (clr),
    .vld     (vld),
    .prod    (prod),
    .sum     (sum),
    .cnt     (cnt),
    .full    (full),
    .out_vld (out_vld)
`ifdef PROD_ACC_AVG_EN
    ,
    .avg     (avg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int window_sum();
    int s = 0;
    foreach (window[i]) s += window[i];
    return s;
  endfunction

  // Reference model: the window is simply the last N accepted products.
  task automatic step(input bit v, input int p, input bit c);
    exp_t e;
    @(negedge clk);
    vld  = v;
    prod = p[2*W-1:0];
    clr  = c;
    e.ov = 0;
    if (c) begin
      window.delete();
    end else if (v) begin
      window.push_back(p);
      if (window.size() > N) void'(window.pop_front());
      e.ov = (window.size() == N);
    end
    e.s = window_sum();
    e.c = window.size();
    e.f = (window.size() == N);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one expected record per stepped edge, compared just after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d: vld=%0b clr=%0b prod=%0d -> sum=%0d cnt=%0d full=%0b out_vld=%0b",
               n_txn, vld, clr, prod, sum, cnt, full, out_vld);
      check("sum", int'(sum), e.s);
      check("cnt", int'(cnt), e.c);
      check("full", int'(full), e.f);
      check("out_vld", int'(out_vld), e.ov);
`ifdef PROD_ACC_AVG_EN
      check("avg", int'(avg), e.s / N);
`endif
    end
  end

  task automatic expect_now(input string name, input int s, input int c, input int ov);
    #2;
    check({name, "_sum"}, int'(sum), s);
    check({name, "_cnt"}, int'(cnt), c);
    check({name, "_out_vld"}, int'(out_vld), ov);
  endtask

  task automatic async_reset();
    #3;
    rst_b = 1'b0;
    vld   = 1'b0;
    clr   = 1'b0;
    window.delete();
    #1;
    check("rst_sum", int'(sum), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_full", int'(full), 0);
    check("rst_out_vld", int'(out_vld), 0);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    int a;
    int b;
    rst_b = 1'b1;
    clr   = 1'b0;
    vld   = 1'b0;
    prod  = '0;
    #2;
    async_reset();

    // Fill sequence and first full-window output.
    step(1, 50, 0);  expect_now("fill1", 50, 1, 0);
    step(1, 25, 0);  expect_now("fill2", 75, 2, 0);
    step(1, 10, 0);  expect_now("fill3", 85, 3, 0);
    step(1, 65, 0);  expect_now("fill4", 150, 4, 1);
    step(1, 169, 0); expect_now("slide", 269, 4, 1);
`ifdef PROD_ACC_AVG_EN
    check("avg_269", int'(avg), 67);
`endif
    for (int i = 0; i < 5; i++) step(1, 225, 0);
    expect_now("max", 900, 4, 1);

    // Idle cycles in FULL hold the sum and suppress out_vld.
    for (int i = 0; i < 5; i++) step(0, 99, 0);
    expect_now("hold", 900, 4, 0);

    // Clear wins over a simultaneous product.
    step(1, 10, 1);  expect_now("clr", 0, 0, 0);
    step(1, 3, 0);   expect_now("after_clr", 3, 1, 0);

    // Asynchronous reset mid-window.
    step(1, 4, 0);
    async_reset();
    step(1, 7, 0);   expect_now("after_rst", 7, 1, 0);

    // Randomised traffic with occasional clears and idle gaps.
    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      step($urandom_range(0, 3) != 0, a * b, $urandom_range(0, 39) == 0);
    end

    @(negedge clk);
    vld = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #2;
    check("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prod_acc.md
PROD_ACC -- requirements
Module: prod_acc

Interface
REQ-001 The block SHALL take parameter W, default 4: operand width of the upstream multiplier; product width is 2W.
REQ-002 The block SHALL take parameter N, default 4: sliding-window depth, a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_b, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous window clear, active high.
REQ-006 The block SHALL have port vld, input, 1 bit: the product on prod is sampled this cycle.
REQ-007 The block SHALL have port prod, input, 2W bits: unsigned product from the upstream multiplier stage.
REQ-008 The block SHALL have port sum, output, 2W+log2(N) bits: sum of the last N accepted products.
REQ-009 The block SHALL have port cnt, output, log2(N)+1 bits: number of products currently held, 0..N.
REQ-010 The block SHALL have port full, output, 1 bit: asserted when cnt == N.
REQ-011 The block SHALL have port out_vld, output, 1 bit: one-cycle pulse when sum holds a fresh full-window value.

Function
REQ-012 The block SHALL use states IDLE, FILL and FULL.
- IDLE -> FILL on the first accepted vld.
- FILL -> FULL when cnt reaches N.
- FULL remains FULL on further vld.
- clr forces IDLE from any state.
REQ-013 On a clk edge with vld=1 and clr=0, prod SHALL be written into an N-entry circular buffer at the write pointer, and the pointer SHALL advance modulo N (N-1 wraps to 0).
REQ-014 In IDLE and FILL, an accepted product SHALL update sum <= sum + prod and cnt <= cnt + 1.
REQ-015 In FULL, an accepted product SHALL update sum <= sum + prod - oldest, where oldest is the entry being overwritten; cnt stays N.
REQ-016 sum, cnt and full SHALL be registered and updated in the same edge that accepts vld (latency 1 cycle from vld to visible result).
REQ-017 out_vld SHALL be 1 for exactly the cycle after each accepted product that leaves cnt == N, including the transition into FULL, and 0 otherwise.
REQ-018 Summation SHALL be unsigned and cannot overflow: the width is sized for N*(2^W-1)^2.
REQ-019 vld=0 SHALL leave all state unchanged and drive out_vld=0.
REQ-020 clr=1 SHALL clear sum, cnt, full, out_vld and the write pointer on the next edge; clr has priority over a simultaneous vld, whose product is dropped.
REQ-021 Buffer contents need not be cleared by clr; stale entries SHALL never contribute to sum, because subtraction of the oldest entry occurs only in FULL.

Reset
REQ-022 rst_b=0 SHALL immediately force sum=0, cnt=0, full=0, out_vld=0, write pointer=0 and state IDLE, regardless of clk.
REQ-023 Reset asserted mid-window SHALL discard all partial results; the first vld after rst_b rises SHALL start a new window.

Configuration
REQ-024 With macro PROD_ACC_AVG_EN defined, the block SHALL add output avg, 2W bits, registered and equal to sum >> log2(N) in the same cycle as sum.
REQ-025 Without PROD_ACC_AVG_EN, the avg port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package prod_acc_pkg SHALL hold the state enum (IDLE, FILL, FULL) and a width-helper function for sum width, 2W+log2(N).
REQ-027 The circular buffer SHALL be a sub-module prod_acc_buf: N x 2W storage, write pointer, and a read-oldest output equal to the entry at the write pointer.

Verification (W=4, N=4)
REQ-028 Reset, then vld with prod 50, 25, 10, 65 on consecutive edges -> cnt 1, 2, 3, 4; sum 50, 75, 85, 150; full=1 and out_vld=1 only after the 4th.
REQ-029 Continuing, vld with prod 169 -> sum=269, cnt=4, out_vld pulse; with PROD_ACC_AVG_EN, avg=67.
REQ-030 Five further vld of 225 -> sum=900 (maximum value, no wrap) after the 4th; pointer wraps 3->0 without error.
REQ-031 clr and vld=1 with prod=10 on the same edge -> sum=0, cnt=0, full=0, state IDLE; the product 10 is not counted.
REQ-032 rst_b dropped between edges while cnt=2 -> outputs zero immediately; next vld with prod=7 -> sum=7, cnt=1.
REQ-033 vld held 0 for 5 cycles in FULL -> sum unchanged, out_vld remains 0.
